// File: rtl/char_stream_tx_if.sv
// Byte-stream bus between a character producer and char_stream_tx.
// The producer writes bytes; the transmitter reports the display strobe and the FIFO status.
interface char_stream_tx_if #(
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [7:0]    wr_data;
    logic          wr_en;
    logic [7:0]    char;
    logic          en;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          busy;
    logic          overflow;

    modport master (
        output wr_data, wr_en,
        input  char, en, full, empty, count, busy, overflow
    );

    modport slave (
        input  wr_data, wr_en,
        output char, en, full, empty, count, busy, overflow
    );
endinterface

// File: rtl/char_stream_tx.sv
// Buffers bytes in a circular FIFO and strobes each one out to a text-display sink.
//   state | meaning
//   IDLE  | waiting for a byte; pops the FIFO head into char when one is present
//   SETUP | char settled, en held low one cycle
//   HIGH  | en high for HIGH_CYC cycles
//   LOW   | en low for LOW_CYC cycles before the next byte
module char_stream_tx #(
    parameter int DEPTH    = 16,
    parameter int HIGH_CYC = 2,
    parameter int LOW_CYC  = 2
) (
    input  logic             clk,
    input  logic             reset,
    char_stream_tx_if.slave  bus
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int TMAX = (HIGH_CYC > LOW_CYC) ? HIGH_CYC : LOW_CYC;
    localparam int TW   = $clog2(TMAX) + 1;

    typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_r, count_nxt;
    logic          full_r, empty_r, ovf_r;
    logic [7:0]    char_r;
    logic          en_r;
    logic          push, pop;

    assign pop  = (state == IDLE) && !empty_r;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign push = bus.wr_en && (!full_r || pop);

    always_comb begin
        count_nxt = count_r;
        case ({push, pop})
            2'b10:   count_nxt = count_r + CW'(1);
            2'b01:   count_nxt = count_r - CW'(1);
            default: count_nxt = count_r;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= bus.wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
            ovf_r   <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count_r <= count_nxt;
            full_r  <= (count_nxt == CW'(DEPTH));
            empty_r <= (count_nxt == '0);
            if (bus.wr_en && !push)
                ovf_r <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        case (state)
            IDLE: begin
                if (!empty_r)
                    state_nxt = SETUP;
            end
            SETUP: begin
                state_nxt = HIGH;
                timer_nxt = TW'(HIGH_CYC - 1);
            end
            HIGH: begin
                if (timer == '0) begin
                    state_nxt = LOW;
                    timer_nxt = TW'(LOW_CYC - 1);
                end else begin
                    timer_nxt = timer - TW'(1);
                end
            end
            LOW: begin
                if (timer == '0)
                    state_nxt = IDLE;
                else
                    timer_nxt = timer - TW'(1);
            end
            default: state_nxt = IDLE;
        endcase
    end

    // en follows the HIGH state one cycle late, so SETUP gives char a full cycle to settle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            timer  <= '0;
            char_r <= 8'h00;
            en_r   <= 1'b0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            en_r  <= (state == HIGH);
            if (pop)
                char_r <= mem[rd_ptr];
        end
    end

    assign bus.char     = char_r;
    assign bus.en       = en_r;
    assign bus.full     = full_r;
    assign bus.empty    = empty_r;
    assign bus.count    = count_r;
    assign bus.busy     = (state != IDLE);
    assign bus.overflow = ovf_r;
endmodule
